mem_block_bridge: RTL and testbench
===================================

# mem_block_bridge

Memory-side bridge directly downstream of the cache controller. It takes the controller's whole-block memory requests (512-bit line fill or write-back) and carries each out as 16 word-wide beats on the external 32-bit memory bus. Read beats are assembled into a full line and returned with a one-cycle completion pulse. It replaces the ideal single-cycle block memory with a realistic narrow, back-pressured bus.

## Interface
- WORD_SIZE, 32, bus word width and address width
- BLOCK_DATA_WIDTH, 512, cache line width
- BLOCK_OFFSET, 4, log2 of words per line; BEATS = 2**BLOCK_OFFSET = BLOCK_DATA_WIDTH/WORD_SIZE = 16
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req_enable  in  1  controller request; a new request is a rising edge of this level
- mem_req_rw  in  1  1 = write-back, 0 = line fill; sampled at acceptance
- mem_req_addr  in  WORD_SIZE  byte address; low BLOCK_OFFSET+2 bits ignored
- mem_req_dataout  in  BLOCK_DATA_WIDTH  write-back line; sampled at acceptance
- mem_req_datain  out  BLOCK_DATA_WIDTH  assembled fill line
- mem_req_ready  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after acceptance through the ready pulse
- bus_valid  out  1  beat request valid
- bus_ready  in  1  memory accepts the beat when bus_valid && bus_ready
- bus_rw  out  1  beat direction, 1 = write
- bus_addr  out  WORD_SIZE  beat byte address
- bus_wdata  out  WORD_SIZE  write beat data
- bus_rdata  in  WORD_SIZE  read return data
- bus_rvalid  in  1  read return strobe, in order, at least 1 cycle after acceptance

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: a request is accepted when mem_req_enable is high and was low the previous cycle. The edge register resets to 0, so enable high straight out of reset counts as an edge. On acceptance, latch base = mem_req_addr & ~((1<<(BLOCK_OFFSET+2))-1), latch rw and the write line, clear both counters, go to WRITE or READ.
- WRITE: bus_valid=1, bus_rw=1, bus_addr = base + 4*req_cnt, bus_wdata = line[req_cnt*32 +: 32].
  - req_cnt increments on each accepted beat.
  - The accept of beat 15 moves to DONE.
- READ: bus_valid=1 while req_cnt < 16, with bus_rw=0 and addresses as in WRITE.
  - Requests and returns overlap freely.
  - Each bus_rvalid writes bus_rdata into mem_req_datain[rsp_cnt*32 +: 32] and increments rsp_cnt.
  - The 16th return moves to DONE.
- DONE: mem_req_ready=1 for exactly one cycle, then IDLE.
- mem_req_datain holds its last value until the next fill overwrites it beat by beat. Write-backs leave it untouched.
- bus_rvalid in IDLE, WRITE or DONE, or after rsp_cnt reaches 16, is ignored.
- Enable edges while not in IDLE are not queued. The edge register still tracks the level, so the controller must drop enable and reassert it after the ready pulse.
- Address arithmetic is mod 2**WORD_SIZE. Lines never cross a block boundary, so no carry into the tag/index bits occurs.

## Timing
- Reset values: state IDLE; mem_req_ready, busy, bus_valid, bus_rw all 0; bus_addr, bus_wdata, mem_req_datain all 0; counters 0.
- Reset mid-transfer aborts immediately: bus_valid drops the next cycle, no ready pulse, partial line discarded.
- Acceptance cycle is T. Beat 0 is presented at T+1.
- Write with bus_ready held high: beats at T+1..T+16, ready pulse at T+17.
- Read with rdata one cycle after each accept: returns at T+2..T+17, ready pulse at T+18.
- Each bus_ready-low cycle adds one cycle and holds bus_addr/bus_wdata stable.
- bus_valid is never withdrawn before acceptance.
- DONE to IDLE takes one cycle. The earliest next acceptance is T+19 for a read.

## Structure
- Shared package cache_pkg holds WORD_SIZE, BLOCK_DATA_WIDTH, BLOCK_OFFSET, the BEATS constant and the bridge_state_t enum (IDLE, WRITE, READ, DONE). The cache controller imports the same package.
- One sub-module, block_assembler: 512-bit register with a word-indexed write port and a clear-free hold. It is used for mem_req_datain.
- Beat multiplexing of the write line stays in the top.

## Test plan
- Fill: rising edge with addr 0x0000_0ABC, rw=0; bus_ready=1; memory returns 0xDEADBEEF+i one cycle after each accept. Required: bus_addr 0x0000_0A80..0x0000_0ABC step 4; mem_req_ready at T+18; mem_req_datain[i*32+:32] = 0xDEADBEEF+i.
- Write-back: addr 0x0000_0DEF, rw=1, line word i = 0xCAFE0000+i, bus_ready=1. Required: 16 beats at 0x0000_0DC0.. with matching wdata; ready pulse at T+17; mem_req_datain unchanged.
- Back-pressure: fill with bus_ready low on alternate cycles. Required: bus_addr held stable while stalled; no beat skipped or duplicated; ready pulse 8 cycles later than in the no-stall case.
- Level hold: enable held high through the ready pulse. Required: no second transfer; a new edge after enable drops for 1 cycle is serviced.
- Reset mid-read: rst high for one cycle after 7 returns. Required: IDLE next cycle, all outputs at reset values, no ready pulse; a following full fill completes correctly.
- Stray rvalid in IDLE with bus_rdata 0xFFFFFFFF. Required: mem_req_datain unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache/memory constants, the bridge state type and block address helpers.
// Imported by the cache controller and by every bridge file.
package cache_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_DATA_WIDTH = 512;
    localparam int BLOCK_OFFSET     = 4;
    localparam int BEATS            = 1 << BLOCK_OFFSET;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bridge_state_t;

    // Byte-offset bits covered by one line: word index plus the 2 byte bits.
    localparam logic [WORD_SIZE-1:0] LINE_OFFSET_MASK =
        WORD_SIZE'((1 << (BLOCK_OFFSET + 2)) - 1);

    function automatic logic [WORD_SIZE-1:0] block_base(input logic [WORD_SIZE-1:0] addr);
        return addr & ~LINE_OFFSET_MASK;
    endfunction

    function automatic logic [WORD_SIZE-1:0] beat_addr(input logic [WORD_SIZE-1:0] base,
                                                      input logic [BLOCK_OFFSET-1:0] idx);
        return base + {{(WORD_SIZE - BLOCK_OFFSET - 2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/block_assembler.sv
// Line-wide register written one word at a time; unwritten words keep their old value,
// so a fill replaces the previous line beat by beat.
module block_assembler
    import cache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [BLOCK_OFFSET-1:0]     wr_idx,
    input  logic [WORD_SIZE-1:0]        wr_data,
    output logic [BLOCK_DATA_WIDTH-1:0] block
);

    always_ff @(posedge clk) begin
        if (rst) begin
            block <= '0;
        end else if (wr_en) begin
            block[wr_idx*WORD_SIZE +: WORD_SIZE] <= wr_data;
        end
    end

endmodule

// File: rtl/mem_block_bridge.sv
// Splits a whole-line memory request into 16 word beats on a narrow valid/ready bus
// and reassembles fill data, finishing each request with a one-cycle ready pulse.
module mem_block_bridge
    import cache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_req_enable,
    input  logic                        mem_req_rw,
    input  logic [WORD_SIZE-1:0]        mem_req_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
    output logic                        mem_req_ready,
    output logic                        busy,
    output logic                        bus_valid,
    input  logic                        bus_ready,
    output logic                        bus_rw,
    output logic [WORD_SIZE-1:0]        bus_addr,
    output logic [WORD_SIZE-1:0]        bus_wdata,
    input  logic [WORD_SIZE-1:0]        bus_rdata,
    input  logic                        bus_rvalid
);

    localparam logic [BLOCK_OFFSET:0]   CNT_ONE   = (BLOCK_OFFSET + 1)'(1);
    localparam logic [BLOCK_OFFSET:0]   CNT_LAST  = (BLOCK_OFFSET + 1)'(BEATS - 1);
    localparam logic [BLOCK_OFFSET:0]   CNT_FULL  = (BLOCK_OFFSET + 1)'(BEATS);
    localparam logic [BLOCK_OFFSET-1:0] IDX_ONE   = BLOCK_OFFSET'(1);

    bridge_state_t               state;
    logic                        en_q;
    logic [WORD_SIZE-1:0]        base;
    logic [BLOCK_DATA_WIDTH-1:0] line;
    logic [BLOCK_OFFSET:0]       req_cnt;
    logic [BLOCK_OFFSET:0]       rsp_cnt;
    logic [BLOCK_OFFSET-1:0]     next_idx;
    logic                        accept;
    logic                        beat_fire;
    logic                        rsp_fire;

    assign accept    = (state == IDLE) && mem_req_enable && !en_q;
    assign beat_fire = bus_valid && bus_ready;
    assign rsp_fire  = (state == READ) && bus_rvalid && (rsp_cnt < CNT_FULL);
    assign next_idx  = req_cnt[BLOCK_OFFSET-1:0] + IDX_ONE;

    // Request payload: captured once at acceptance, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            base <= block_base(mem_req_addr);
            line <= mem_req_dataout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            en_q          <= 1'b0;
            req_cnt       <= '0;
            rsp_cnt       <= '0;
            mem_req_ready <= 1'b0;
            busy          <= 1'b0;
            bus_valid     <= 1'b0;
            bus_rw        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
        end else begin
            // Edge detector tracks the level in every state, so a held enable never re-triggers.
            en_q <= mem_req_enable;

            case (state)
                IDLE: begin
                    if (accept) begin
                        req_cnt   <= '0;
                        rsp_cnt   <= '0;
                        busy      <= 1'b1;
                        bus_valid <= 1'b1;
                        bus_rw    <= mem_req_rw;
                        bus_addr  <= block_base(mem_req_addr);
                        bus_wdata <= mem_req_dataout[WORD_SIZE-1:0];
                        state     <= mem_req_rw ? WRITE : READ;
                    end
                end

                WRITE: begin
                    if (beat_fire) begin
                        req_cnt <= req_cnt + CNT_ONE;
                        if (req_cnt == CNT_LAST) begin
                            bus_valid     <= 1'b0;
                            bus_rw        <= 1'b0;
                            mem_req_ready <= 1'b1;
                            state         <= DONE;
                        end else begin
                            bus_addr  <= beat_addr(base, next_idx);
                            bus_wdata <= line[next_idx*WORD_SIZE +: WORD_SIZE];
                        end
                    end
                end

                READ: begin
                    // Requests and returns advance independently; only the last return ends the fill.
                    if (beat_fire) begin
                        req_cnt <= req_cnt + CNT_ONE;
                        if (req_cnt == CNT_LAST) begin
                            bus_valid <= 1'b0;
                        end else begin
                            bus_addr <= beat_addr(base, next_idx);
                        end
                    end
                    if (rsp_fire) begin
                        rsp_cnt <= rsp_cnt + CNT_ONE;
                        if (rsp_cnt == CNT_LAST) begin
                            mem_req_ready <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end

                DONE: begin
                    mem_req_ready <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    block_assembler u_assembler (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rsp_fire),
        .wr_idx  (rsp_cnt[BLOCK_OFFSET-1:0]),
        .wr_data (bus_rdata),
        .block   (mem_req_datain)
    );

endmodule

// File: tb/tb_mem_block_bridge.sv
// Self-checking bench: a bus memory model drives the bridge and a line-level model
// predicts addresses, write data, completion timing and the assembled fill line.
module tb_mem_block_bridge;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req_enable;
    logic         mem_req_rw;
    logic [31:0]  mem_req_addr;
    logic [511:0] mem_req_dataout;
    logic [511:0] mem_req_datain;
    logic         mem_req_ready;
    logic         busy;
    logic         bus_valid;
    logic         bus_ready;
    logic         bus_rw;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_rvalid;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [511:0] exp_datain = '0;

    mem_block_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_enable  (mem_req_enable),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_datain  (mem_req_datain),
        .mem_req_ready   (mem_req_ready),
        .busy            (busy),
        .bus_valid       (bus_valid),
        .bus_ready       (bus_ready),
        .bus_rw          (bus_rw),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .bus_rvalid      (bus_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},  mem_req_ready,  0);
        check_eq({tag, "_busy"},   busy,           0);
        check_eq({tag, "_valid"},  bus_valid,      0);
        check_eq({tag, "_rw"},     bus_rw,         0);
        check_eq({tag, "_addr"},   bus_addr,       0);
        check_eq({tag, "_wdata"},  bus_wdata,      0);
        check_eq({tag, "_datain"}, mem_req_datain, 0);
    endtask

    // Called just after a falling edge. mode: 0 = always ready, 1 = one stall before each
    // odd beat, 2 = random ready and random in-order return latency.
    task automatic do_xfer(input logic rw, input logic [31:0] addr, input logic [511:0] wline,
                           input int mode, input logic [31:0] seed, input bit hold,
                           input int abort_after, output int done_at);
        logic [31:0]  base;
        logic [511:0] line_exp;
        int           c, acc, rsp, stall_idx, t;
        int           ret_time[16];
        bit           rdy, abort_now, timed_out;

        base      = addr & 32'hFFFF_FFC0;
        line_exp  = exp_datain;
        done_at   = -1;
        c = 0; acc = 0; rsp = 0; stall_idx = -1;
        abort_now = 0; timed_out = 0;
        mem_req_enable  = 1'b1;
        mem_req_rw      = rw;
        mem_req_addr    = addr;
        mem_req_dataout = wline;
        bus_ready       = 1'b0;
        bus_rvalid      = 1'b0;
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            c++;
            if (!hold) mem_req_enable = 1'b0;
            mem_req_rw      = ~rw;
            mem_req_addr    = $urandom;
            mem_req_dataout = {16{$urandom}};
            if (c > 300) begin
                check_eq("xfer_timeout", c, 300);
                timed_out = 1;
                break;
            end
            check_eq("busy",  busy,          1);
            check_eq("ready", mem_req_ready, c == done_at);
            check_eq("valid", bus_valid,     acc < 16);
            if (bus_valid) begin
                check_eq("beat_addr", bus_addr, base + 32'(4 * acc));
                check_eq("beat_rw",   bus_rw,   rw);
                if (rw) check_eq("beat_wdata", bus_wdata, wline[acc*32 +: 32]);
            end
            if (c == done_at) break;
            if (abort_now) begin
                rst = 1'b1; bus_ready = 1'b0; bus_rvalid = 1'b0;
                @(negedge clk);
                check_reset_outputs("abort");
                rst = 1'b0;
                @(negedge clk);
                check_eq("abort_no_ready", mem_req_ready, 0);
                check_eq("abort_idle_busy", busy, 0);
                check_eq("abort_idle_valid", bus_valid, 0);
                exp_datain = '0;
                return;
            end
            rdy = 1'b1;
            if (mode == 1 && (acc % 2) == 1 && stall_idx != acc) begin
                rdy = 1'b0;
                stall_idx = acc;
            end else if (mode == 2) begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            bus_ready = rdy;
            if (!rw && rsp < acc && ret_time[rsp] == c) begin
                bus_rvalid = 1'b1;
                bus_rdata  = seed + 32'(rsp);
                line_exp[rsp*32 +: 32] = seed + 32'(rsp);
                rsp++;
                if (rsp == 16) done_at = c + 1;
                if (abort_after > 0 && rsp == abort_after) abort_now = 1;
            end else begin
                bus_rvalid = rw ? 1'($urandom_range(0, 1)) : 1'b0;
                bus_rdata  = $urandom;
            end
            if (bus_valid && rdy) begin
                if (!rw) begin
                    t = c + ((mode == 2) ? int'($urandom_range(1, 3)) : 1);
                    if (acc > 0 && t <= ret_time[acc-1]) t = ret_time[acc-1] + 1;
                    ret_time[acc] = t;
                end
                acc++;
                if (rw && acc == 16) done_at = c + 1;
            end
        end
        if (timed_out) return;
        // Stray return during the completion cycle must be ignored.
        bus_ready  = 1'($urandom_range(0, 1));
        bus_rvalid = 1'b1;
        bus_rdata  = $urandom;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_ready  = 1'b0;
        mem_req_enable = hold;
        check_eq("post_ready", mem_req_ready, 0);
        check_eq("post_busy",  busy,          0);
        check_eq("post_valid", bus_valid,     0);
        check_eq("datain",     mem_req_datain, line_exp);
        exp_datain = line_exp;
    endtask

    initial begin
        logic [511:0] wl;
        int           d;
        rst = 1'b1;
        mem_req_enable = 1'b1;
        mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_dataout = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Enable already high out of reset counts as a request edge.
        do_xfer(1'b0, 32'h0000_0ABC, '0, 0, 32'hDEAD_BEEF, 1'b0, 0, d);
        check_eq("fill_latency", d, 18);

        for (int i = 0; i < 16; i++) wl[i*32 +: 32] = 32'hCAFE_0000 + 32'(i);
        do_xfer(1'b1, 32'h0000_0DEF, wl, 0, 32'h0, 1'b0, 0, d);
        check_eq("write_latency", d, 17);

        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        @(negedge clk);
        check_eq("stray_rvalid_idle", mem_req_datain, exp_datain);

        do_xfer(1'b0, 32'h1234_5678, '0, 1, 32'h1000_0000, 1'b0, 0, d);
        check_eq("stall_latency", d, 26);

        do_xfer(1'b0, 32'h0000_4000, '0, 0, 32'h5555_0000, 1'b1, 0, d);
        check_eq("hold_latency", d, 18);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("hold_no_valid", bus_valid, 0);
            check_eq("hold_no_busy",  busy,      0);
        end
        mem_req_enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) wl[i*32 +: 32] = $urandom;
        do_xfer(1'b1, 32'h0000_4040, wl, 0, 32'h0, 1'b0, 0, d);
        check_eq("reedge_latency", d, 17);

        do_xfer(1'b0, 32'h0000_8000, '0, 0, 32'hA000_0000, 1'b0, 7, d);
        do_xfer(1'b0, 32'h0000_8000, '0, 0, 32'hB000_0000, 1'b0, 0, d);
        check_eq("after_abort_latency", d, 18);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) wl[i*32 +: 32] = $urandom;
            do_xfer(1'($urandom_range(0, 1)), $urandom, wl, 2, $urandom, 1'b0, 0, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
